// File: rtl/car_speed_ctrl_n.sv
// N-level car speed controller with hold-qualified accelerate/brake stepping,
// a cruise-hold mode and an emergency-stop lockout.
module car_speed_ctrl_n #(
  parameter int unsigned SPEED_W   = 3,
  parameter int unsigned MAX_SPEED = 5,
  parameter int unsigned ACC_HOLD  = 4,
  parameter int unsigned BRK_HOLD  = 2,
  parameter int unsigned CNT_W     = 8
) (
  input  logic               clock_i,
  input  logic               keys_i,
  input  logic               accelerate_i,
  input  logic               brake_i,
  input  logic               cruise_set_i,
  input  logic               cruise_cancel_i,
  input  logic               estop_i,
  output logic [SPEED_W-1:0] speed_o,
  output logic               cruise_active_o,
  output logic               at_max_o,
  output logic               locked_o
);

  localparam logic [SPEED_W-1:0] SPEED_MAX = SPEED_W'(MAX_SPEED);
  localparam logic [SPEED_W-1:0] SPEED_ONE = SPEED_W'(1);
  localparam logic [CNT_W-1:0]   ACC_LAST  = CNT_W'(ACC_HOLD - 1);
  localparam logic [CNT_W-1:0]   BRK_LAST  = CNT_W'(BRK_HOLD - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_CRUISE = 2'd2,
    ST_ESTOP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_ACC  = 2'd1,
    REQ_BRK  = 2'd2
  } req_e;

  state_e             state_q, state_d;
  req_e               req_q, req_d;
  req_e               win_c;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   eff_cnt_c;
  logic               acc_step_c, brk_step_c;
  logic               cruise_q, cruise_d;
  logic               locked_q, locked_d;
  logic               at_max_q, at_max_d;

  // State, speed, hold counter and registered status flags
  always_ff @(posedge clock_i or negedge keys_i) begin
    if (!keys_i) begin
      state_q  <= ST_IDLE;
      req_q    <= REQ_NONE;
      speed_q  <= '0;
      cnt_q    <= '0;
      cruise_q <= 1'b0;
      locked_q <= 1'b0;
      at_max_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      speed_q  <= speed_d;
      cnt_q    <= cnt_d;
      cruise_q <= cruise_d;
      locked_q <= locked_d;
      at_max_q <= at_max_d;
    end
  end

  // Next-state, stepping and counter logic
  always_comb begin
    state_d = state_q;
    speed_d = speed_q;
    cnt_d   = '0;
    req_d   = REQ_NONE;

    // Brake outranks accelerate; a change of winner restarts the hold count
    if (brake_i)           win_c = REQ_BRK;
    else if (accelerate_i) win_c = REQ_ACC;
    else                   win_c = REQ_NONE;
    eff_cnt_c  = (win_c == req_q) ? cnt_q : '0;
    acc_step_c = (eff_cnt_c == ACC_LAST);
    brk_step_c = (eff_cnt_c == BRK_LAST);

    if (estop_i) begin
      state_d = ST_ESTOP;
      speed_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!brake_i && accelerate_i) begin
            req_d = REQ_ACC;
            if (acc_step_c) begin
              speed_d = SPEED_ONE;
              state_d = ST_MANUAL;
            end else begin
              cnt_d = eff_cnt_c + CNT_ONE;
            end
          end
        end
        ST_MANUAL: begin
          if (brake_i) begin
            if (speed_q != '0) begin
              req_d = REQ_BRK;
              if (brk_step_c) begin
                speed_d = speed_q - SPEED_ONE;
                if (speed_q == SPEED_ONE) state_d = ST_IDLE;
              end else begin
                cnt_d = eff_cnt_c + CNT_ONE;
              end
            end
          end else if (accelerate_i) begin
            if (speed_q < SPEED_MAX) begin
              req_d = REQ_ACC;
              if (acc_step_c) speed_d = speed_q + SPEED_ONE;
              else            cnt_d   = eff_cnt_c + CNT_ONE;
            end
          end else if (cruise_set_i) begin
            state_d = ST_CRUISE;
          end
        end
        ST_CRUISE: begin
          if (brake_i || cruise_cancel_i) state_d = ST_MANUAL;
        end
        ST_ESTOP: begin
          if (!brake_i && !accelerate_i) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          speed_d = '0;
        end
      endcase
    end

    cruise_d = (state_d == ST_CRUISE);
    locked_d = (state_d == ST_ESTOP);
    at_max_d = (speed_d == SPEED_MAX);
  end

  assign speed_o         = speed_q;
  assign cruise_active_o = cruise_q;
  assign at_max_o        = at_max_q;
  assign locked_o        = locked_q;

endmodule
